// File: rtl/mul_div_sequencer.sv
// Moore control sequencer for the 4-bit ALU/accumulator datapath: issues the
// per-cycle control vector for a 4x4 shift-add multiply or a 4/4 restoring divide.
module mul_div_sequencer (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       start,
    input  logic       op_sel,
    input  logic [3:0] breg_data,
    output logic       bus_req,
    output logic       acc_high_reset_p,
    output logic       acc_in_select,
    output logic [1:0] acc_high_select,
    output logic [1:0] acc_low_select,
    output logic       op_add,
    output logic       op_sub,
    output logic       op_mul,
    output logic       op_div,
    output logic       op_and,
    output logic       rd_en,
    output logic       busy,
    output logic       done,
    output logic       div_zero
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_H,
        S_COPY_L,
        S_CLR_H,
        S_MUL_ADD,
        S_MUL_SHR,
        S_DIV_SHL,
        S_DIV_SUB,
        S_DIV_LAST,
        S_DONE
    } state_t;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] it_q, it_d;
    logic       op_r_q, op_r_d;
    logic       div_zero_q, div_zero_d;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset_p) begin
            state_q    <= S_IDLE;
            it_q       <= 2'd0;
            op_r_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            it_q       <= it_d;
            op_r_q     <= op_r_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a hold default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        it_d       = it_q;
        op_r_d     = op_r_q;
        div_zero_d = div_zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_zero_d = 1'b0;
                    if (op_sel && (breg_data == 4'd0)) begin
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        op_r_d  = op_sel;
                        state_d = S_LOAD_H;
                    end
                end
            end
            S_LOAD_H: state_d = S_COPY_L;
            S_COPY_L: state_d = S_CLR_H;
            S_CLR_H: begin
                it_d    = 2'd0;
                state_d = op_r_q ? S_DIV_SHL : S_MUL_ADD;
            end
            S_MUL_ADD: state_d = S_MUL_SHR;
            S_MUL_SHR: begin
                if (it_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    it_d    = it_q + 2'd1;
                    state_d = S_MUL_ADD;
                end
            end
            S_DIV_SHL: state_d = S_DIV_SUB;
            S_DIV_SUB: begin
                if (it_q == 2'd3) begin
                    state_d = S_DIV_LAST;
                end else begin
                    it_d    = it_q + 2'd1;
                    state_d = S_DIV_SHL;
                end
            end
            S_DIV_LAST: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode; only the registered state drives the control vector.
    always_comb begin
        bus_req          = 1'b0;
        acc_high_reset_p = 1'b0;
        acc_in_select    = 1'b0;
        acc_high_select  = SEL_HOLD;
        acc_low_select   = SEL_HOLD;
        op_add           = 1'b0;
        op_sub           = 1'b0;
        op_mul           = 1'b0;
        op_div           = 1'b0;
        op_and           = 1'b0;
        rd_en            = 1'b0;
        done             = 1'b0;
        div_zero         = 1'b0;
        busy             = (state_q != S_IDLE);
        unique case (state_q)
            S_LOAD_H: begin
                bus_req         = 1'b1;
                acc_in_select   = 1'b1;
                acc_high_select = SEL_LOAD;
            end
            S_COPY_L:  acc_low_select   = SEL_LOAD;
            S_CLR_H:   acc_high_reset_p = 1'b1;
            S_MUL_ADD: op_mul           = 1'b1;
            S_MUL_SHR: begin
                acc_high_select = SEL_SHR;
                acc_low_select  = SEL_SHR;
            end
            S_DIV_SHL: begin
                acc_high_select = SEL_SHL;
                acc_low_select  = SEL_SHL;
            end
            S_DIV_SUB:  op_div         = 1'b1;
            S_DIV_LAST: acc_low_select = SEL_SHL;
            S_DONE: begin
                done     = 1'b1;
                rd_en    = 1'b1;
                div_zero = div_zero_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: a schedule-based control model plus a behavioural
// accumulator driven by the DUT's own controls, checked every cycle.
module tb_mul_div_sequencer;

    typedef struct packed {
        logic       bus_req;
        logic       acc_high_reset_p;
        logic       acc_in_select;
        logic [1:0] hsel;
        logic [1:0] lsel;
        logic       op_add;
        logic       op_sub;
        logic       op_mul;
        logic       op_div;
        logic       op_and;
        logic       rd_en;
        logic       busy;
        logic       done;
        logic       div_zero;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       start = 1'b0;
    logic       op_sel = 1'b0;
    logic [3:0] breg = 4'd0;
    logic       bus_req, acc_high_reset_p, acc_in_select;
    logic [1:0] acc_high_select, acc_low_select;
    logic       op_add, op_sub, op_mul, op_div, op_and;
    logic       rd_en, busy, done, div_zero;

    logic [3:0] a_val = 4'd0;
    int         n_cmp = 0;
    int         n_bad = 0;

    mul_div_sequencer dut (
        .clk              (clk),
        .reset_p          (reset_p),
        .start            (start),
        .op_sel           (op_sel),
        .breg_data        (breg),
        .bus_req          (bus_req),
        .acc_high_reset_p (acc_high_reset_p),
        .acc_in_select    (acc_in_select),
        .acc_high_select  (acc_high_select),
        .acc_low_select   (acc_low_select),
        .op_add           (op_add),
        .op_sub           (op_sub),
        .op_mul           (op_mul),
        .op_div           (op_div),
        .op_and           (op_and),
        .rd_en            (rd_en),
        .busy             (busy),
        .done             (done),
        .div_zero         (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic ctl_t mk(input logic br, input logic hr, input logic is,
                                input logic [1:0] hs, input logic [1:0] ls,
                                input logic mul, input logic div,
                                input logic dn, input logic dz);
        ctl_t c = '0;
        c.bus_req = br; c.acc_high_reset_p = hr; c.acc_in_select = is;
        c.hsel = hs; c.lsel = ls; c.op_mul = mul; c.op_div = div;
        c.rd_en = dn; c.done = dn; c.div_zero = dz; c.busy = 1'b1;
        return c;
    endfunction

    // Expected control schedule, one entry per cycle of an operation.
    ctl_t       sched[$];
    ctl_t       cur = '0;
    bit         cur_idle = 1'b1;
    bit         model_valid = 1'b0;
    logic [7:0] exp_res = 8'd0;

    // Behavioural accumulator; the extra high bit and carry model the ALU flags.
    logic [3:0] acc_h = 4'd0, acc_l = 4'd0;
    logic       carry = 1'b0, qbit = 1'b0;
    logic [7:0] bus_snap = 8'd0;

    task automatic push_op(input logic is_div);
        sched.push_back(mk(1, 0, 1, 2'b11, 2'b00, 0, 0, 0, 0));
        sched.push_back(mk(0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0));
        sched.push_back(mk(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            if (is_div) begin
                sched.push_back(mk(0, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0));
                sched.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0));
            end else begin
                sched.push_back(mk(0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0));
                sched.push_back(mk(0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0));
            end
        end
        if (is_div) sched.push_back(mk(0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0));
        sched.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0));
    endtask

    always @(posedge clk) begin
        if (reset_p) begin
            sched.delete();
            cur = '0; cur_idle = 1'b1; model_valid = 1'b1;
        end else if (model_valid) begin
            if (cur_idle && start) begin
                if (op_sel && breg == 4'd0) begin
                    sched.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1));
                    exp_res = {acc_h, acc_l};
                end else begin
                    push_op(op_sel);
                    if (op_sel) exp_res = {a_val % breg, a_val / breg};
                    else        exp_res = 8'(a_val * breg);
                end
            end
            if (sched.size() > 0) begin
                cur = sched.pop_front(); cur_idle = 1'b0;
            end else begin
                cur = '0; cur_idle = 1'b1;
            end
        end
    end

    // Single compare process: control vector every cycle, result on done.
    always @(negedge clk) begin
        ctl_t       got;
        logic [4:0] t;
        if (model_valid) begin
            got = {bus_req, acc_high_reset_p, acc_in_select, acc_high_select, acc_low_select,
                   op_add, op_sub, op_mul, op_div, op_and, rd_en, busy, done, div_zero};
            check("ctl", 32'(got), 32'(cur));
            if (cur.done) begin
                bus_snap = {acc_h, acc_l};
                check("result", 32'(bus_snap), 32'(exp_res));
            end
            if (got.acc_high_reset_p) acc_h = 4'd0;
            if (got.hsel == 2'b11 && got.acc_in_select) acc_h = a_val;
            if (got.lsel == 2'b11) acc_l = acc_h;
            if (got.op_mul && got.hsel == 2'b00) begin
                if (acc_l[0]) {carry, acc_h} = acc_h + breg;
                else carry = 1'b0;
            end
            if (got.hsel == 2'b01 && got.lsel == 2'b01) begin
                {acc_h, acc_l} = {carry, acc_h, acc_l[3:1]};
                carry = 1'b0;
            end
            if (got.hsel == 2'b10 && got.lsel == 2'b10) begin
                {carry, acc_h, acc_l} = {acc_h, acc_l, qbit};
            end
            if (got.op_div && got.hsel == 2'b00) begin
                t = {carry, acc_h} - {1'b0, breg};
                qbit = ({carry, acc_h} >= {1'b0, breg});
                if (qbit) acc_h = t[3:0];
                carry = 1'b0;
            end
            if (got.hsel == 2'b00 && got.lsel == 2'b10) acc_l = {acc_l[2:0], qbit};
        end
    end

    // Directed operation with hand-computed bus value and done latency.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic op,
                          input logic [7:0] lit, input int lat, input logic dz_lit);
        int n = 0;
        int nbus = 0;
        @(negedge clk);
        a_val = a; breg = b; op_sel = op; start = 1'b1;
        do begin
            @(negedge clk); #1;
            n++;
            start = 1'b0;
            if (bus_req) nbus++;
        end while (!done && n < 40);
        check("latency", 32'(n), 32'(lat));
        check("bus_value", 32'(bus_snap), 32'(lit));
        check("div_zero", 32'(div_zero), 32'(dz_lit));
        check("bus_req_cycles", 32'(nbus), dz_lit ? 32'd0 : 32'd1);
        @(negedge clk); #1;
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!done && n < 40);
    endtask

    initial begin
        int n;
        int ndone;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_outputs", {bus_req, acc_high_reset_p, acc_in_select, acc_high_select,
              acc_low_select, op_add, op_sub, op_mul, op_div, op_and, rd_en, done, div_zero}, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset_p = 1'b0;

        run_op(4'd7,  4'd5, 1'b0, 8'h23, 12, 1'b0);
        run_op(4'd15, 4'd15, 1'b0, 8'hE1, 12, 1'b0);
        run_op(4'd0,  4'd9, 1'b0, 8'h00, 12, 1'b0);
        run_op(4'd13, 4'd4, 1'b1, 8'h13, 13, 1'b0);
        run_op(4'd15, 4'd1, 1'b1, 8'h0F, 13, 1'b0);
        run_op(4'd3,  4'd7, 1'b1, 8'h30, 13, 1'b0);
        run_op(4'd11, 4'd0, 1'b1, 8'h30, 1,  1'b1);

        // start held high: next LOAD_H comes two cycles after done
        @(negedge clk);
        a_val = 4'd3; breg = 4'd5; op_sel = 1'b0; start = 1'b1;
        wait_done(n);
        check("held_first_latency", 32'(n), 32'd12);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!bus_req && n < 10);
        check("held_restart_gap", 32'(n), 32'd2);
        start = 1'b0;
        wait_done(n);
        check("held_second_latency", 32'(n), 32'd11);
        check("held_second_value", 32'(bus_snap), 32'h0F);
        @(negedge clk);

        // reset during cycle 6 of a multiply
        @(negedge clk);
        a_val = 4'd6; breg = 4'd9; op_sel = 1'b0; start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
        end
        reset_p = 1'b1;
        @(negedge clk); #1;
        reset_p = 1'b0;
        check("reset_mid_busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); #1;
            if (done) ndone++;
        end
        check("reset_mid_no_done", 32'(ndone), 32'd0);
        run_op(4'd6, 4'd9, 1'b0, 8'h36, 12, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
